seq_nibble_addsub: RTL

//  Multi-cycle WIDTH-bit add/subtract unit for the 32-bit SUB/ADD datapath.

---
 rtl/seq_nibble_addsub.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_nibble_addsub.sv
// seq_nibble_addsub: multi-cycle WIDTH-bit add/subtract unit.
// Accepts an operand pair and an op select, then processes one 4-bit nibble per cycle,
// LSB first, through a 4-bit carry-lookahead nibble adder. The carry is registered
// between nibbles. Results and flags are returned over a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready   operand request handshake (o_ready high only when idle)
//   i_a, i_b, i_sub     operands; i_sub=1 selects A-B, computed as A + ~B + 1
//   o_valid / i_ready   result handshake (o_valid high only when done)
//   o_result            sum/difference modulo 2^WIDTH
//   o_cout              carry out of the MSB (raw carry, also for subtract)
//   o_ovf               signed overflow (carry into MSB xor carry out of MSB)
//   o_zero              o_result == 0
module seq_nibble_addsub #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero
);

   localparam int unsigned NNIB = WIDTH / 4;
   localparam int unsigned IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam logic [IDXW-1:0] LastIdx = IDXW'(NNIB - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   // Nibble carry-lookahead adder
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_p;
   logic [3:0]       nib_g;
   logic [4:0]       nib_c;
   logic [3:0]       nib_sum;
   logic [WIDTH-1:0] result_nxt;

   always_comb begin
      nib_a = a_q[4*idx_q +: 4];
      nib_b = b_q[4*idx_q +: 4];
      nib_p = nib_a ^ nib_b;
      nib_g = nib_a & nib_b;
      nib_c[0] = carry_q;
      nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
      nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
      nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
               | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
      nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
               | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
               | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
      nib_sum = nib_p ^ nib_c[3:0];
      // Full result with the current nibble merged in, so the zero flag sees the final word.
      result_nxt = result_q;
      result_nxt[4*idx_q +: 4] = nib_sum;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_valid) begin
                  a_q     <= i_a;
                  b_q     <= i_sub ? ~i_b : i_b;
                  carry_q <= i_sub;
                  idx_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               result_q <= result_nxt;
               carry_q  <= nib_c[4];
               if (idx_q == LastIdx) begin
                  cout_q  <= nib_c[4];
                  ovf_q   <= nib_c[3] ^ nib_c[4];
                  zero_q  <= (result_nxt == '0);
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StDone: begin
               if (i_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_ready  = (state_q == StIdle);
   assign o_valid  = (state_q == StDone);
   assign o_result = result_q;
   assign o_cout   = cout_q;
   assign o_ovf    = ovf_q;
   assign o_zero   = zero_q;

endmodule
